pix_window: RTL and testbench
=============================

PIX_WINDOW -- requirements
Module: pix_window

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 64, image width in pixels, minimum 2.
REQ-003 Parameter IMG_H, default 128, image height in rows, minimum 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  i_pix carries the next raster pixel; accepted only when i_ready=1.
REQ-007 i_pix  input  PIX_W  input pixel, raster order, row 0 col 0 first.
REQ-008 i_ready  output  1  block can accept a pixel this cycle.
REQ-009 o_valid  output  1  o_data holds one centre-pixel neighbourhood; single-cycle pulse per centre.
REQ-010 o_data  output  4*PIX_W  {top, bot, left, right} of the centre, top in MSBs; feeds the downstream hog i_data directly.

Function
REQ-011 Pixel index k = row*IMG_W + col, N = IMG_W*IMG_H; one neighbourhood output per pixel, exactly N per frame, in raster order.
REQ-012 Neighbours of centre (r,c): top=(r-1,c), bot=(r+1,c), left=(r,c-1), right=(r,c+1).
REQ-013 Out-of-image neighbour (r=0 top, r=IMG_H-1 bot, c=0 left, c=IMG_W-1 right) is zero; no wrap across rows or frames.
REQ-014 Storage: delay line of 2*IMG_W+1 pixels (two line buffers plus taps); advances only on accepted pixels or flush cycles.
REQ-015 States: FILL (k < IMG_W accepted, no output), RUN (output per accepted pixel), FLUSH (IMG_W cycles, zero bot, i_ready=0).
REQ-016 Latency: centre k is output with o_valid=1 in the cycle after pixel k+IMG_W is accepted; registered output.
REQ-017 FILL->RUN when pixel IMG_W-1 accepted; RUN->FLUSH when pixel N-1 accepted; FLUSH->FILL after IMG_W outputs.
REQ-018 FLUSH emits centres N-IMG_W..N-1 on consecutive cycles regardless of i_valid.
REQ-019 i_ready=1 in FILL and RUN, 0 in FLUSH; i_valid while i_ready=0 is ignored and no pixel is lost.
REQ-020 i_valid gaps in FILL/RUN stall the block; o_valid=0 on gap cycles, no state change.
REQ-021 Line buffer contents from the previous frame never reach o_data; row-0 top masked by REQ-013.
REQ-022 No backpressure from downstream; o_valid is never held.

Reset
REQ-023 rst=0 immediately forces state FILL, counters 0, o_valid=0, o_data=0, i_ready=1 (asynchronously).
REQ-024 Reset mid-frame or mid-flush discards the partial frame; next accepted pixel is k=0.
REQ-025 Line buffer RAM content is not cleared by reset.

Configuration
REQ-026 Macro PIX_WINDOW_REPLICATE_EN defined: out-of-image neighbours take the centre pixel value instead of zero.
REQ-027 Macro undefined: zero padding per REQ-013; all other behaviour identical.

Verification
REQ-028 Use IMG_W=4, IMG_H=3, pixel value k+1, i_valid=1 continuously: first o_valid the cycle after pixel 4 accepted, o_data={0,5,0,2}.
REQ-029 Same stream: centre (1,1) value 6 -> o_data={2,10,5,7}; centre (1,3) value 8 -> {4,12,7,0}.
REQ-030 Same stream: after pixel 11, i_ready=0 for 4 cycles, 4 flush outputs, last {8,0,11,0}, total 12 o_valid pulses, then i_ready=1.
REQ-031 Random i_valid gaps and i_valid=1 held during FLUSH: output sequence identical to REQ-028..030, no extra or missing pulses.
REQ-032 Assert rst=0 after pixel 6 of frame 1, then send a full frame: exactly 12 outputs, first {0,5,0,2}.
REQ-033 With PIX_WINDOW_REPLICATE_EN: centre (0,0) -> {1,5,1,2}; centre (2,3) -> {8,12,11,12}.

Source files
------------

// File: rtl/pix_window.sv
// rtl/pix_window.sv - raster 4-neighbour window generator; define PIX_WINDOW_REPLICATE_EN for edge replication instead of zero padding
module pix_window #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [PIX_W-1:0]   i_pix,
  output logic               i_ready,
  output logic               o_valid,
  output logic [4*PIX_W-1:0] o_data
);

  localparam int N   = IMG_W * IMG_H;
  localparam int DLY = 2 * IMG_W;
  localparam int KW  = $clog2(N);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t           state;
  logic [KW-1:0]    in_cnt;
  logic [CW-1:0]    c_col;
  logic [RW-1:0]    c_row;

  // dly[0] is the newest stored pixel; the incoming pixel acts as the extra tap
  logic [PIX_W-1:0] dly [DLY];

  logic             accept;
  logic             shift;
  logic             emit;
  logic [PIX_W-1:0] centre;
  logic [PIX_W-1:0] pad;
  logic [PIX_W-1:0] bot_raw;
  logic [PIX_W-1:0] top_n;
  logic [PIX_W-1:0] bot_n;
  logic [PIX_W-1:0] left_n;
  logic [PIX_W-1:0] right_n;

  // Handshake decode: flush cycles advance the delay line without an input pixel
  always_comb begin
    accept = i_valid & i_ready;
    shift  = accept | (state == S_FLUSH);
    emit   = (accept & (state == S_RUN)) | (state == S_FLUSH);
  end

  // Neighbour taps around the centre, with out-of-image positions padded
  always_comb begin
    centre = dly[IMG_W-1];
`ifdef PIX_WINDOW_REPLICATE_EN
    pad = centre;
`else
    pad = '0;
`endif
    bot_raw = (state == S_FLUSH) ? '0 : i_pix;
    top_n   = (c_row == '0)                 ? pad : dly[DLY-1];
    bot_n   = (c_row == RW'(IMG_H - 1))     ? pad : bot_raw;
    left_n  = (c_col == '0)                 ? pad : dly[IMG_W];
    right_n = (c_col == CW'(IMG_W - 1))     ? pad : dly[IMG_W-2];
  end

  // Delay line: two rows plus one pixel of history; deliberately not reset
  always_ff @(posedge clk) begin
    if (shift) begin
      dly[0] <= bot_raw;
      for (int i = 1; i < DLY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  // Frame sequencer with registered ready, valid and window data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FILL;
      in_cnt  <= '0;
      c_col   <= '0;
      c_row   <= '0;
      i_ready <= 1'b1;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_data <= {top_n, bot_n, left_n, right_n};
        if (c_col == CW'(IMG_W - 1)) begin
          c_col <= '0;
          c_row <= c_row + RW'(1);
        end else begin
          c_col <= c_col + CW'(1);
        end
      end
      case (state)
        S_FILL: begin
          if (accept) begin
            in_cnt <= in_cnt + KW'(1);
            if (in_cnt == KW'(IMG_W - 1)) begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (in_cnt == KW'(N - 1)) begin
              state   <= S_FLUSH;
              i_ready <= 1'b0;
              in_cnt  <= '0;
            end else begin
              in_cnt <= in_cnt + KW'(1);
            end
          end
        end
        S_FLUSH: begin
          // The last row's final centre ends the frame
          if (c_col == CW'(IMG_W - 1)) begin
            state   <= S_FILL;
            i_ready <= 1'b1;
            c_col   <= '0;
            c_row   <= '0;
          end
        end
        default: begin
          state   <= S_FILL;
          i_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pix_window.sv
// tb/tb_pix_window.sv - randomized self-checking bench for pix_window against a frame-level neighbourhood model
module tb_pix_window;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic [PW-1:0]   i_pix;
  logic            i_ready;
  logic            o_valid;
  logic [4*PW-1:0] o_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [PW-1:0]   frame [N];
  int              acc   [N];
  logic [4*PW-1:0] obs   [N];
  int              out_cnt;
  int              ready_low;

  pix_window #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_pix   (i_pix),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*PW-1:0] model(input int k);
    int r;
    int c;
    logic [PW-1:0] pad, t, b, l, rt;
    r = k / W;
    c = k % W;
`ifdef PIX_WINDOW_REPLICATE_EN
    pad = frame[k];
`else
    pad = '0;
`endif
    t = pad; b = pad; l = pad; rt = pad;
    if (r > 0)     t  = frame[k-W];
    if (r < H - 1) b  = frame[k+W];
    if (c > 0)     l  = frame[k-1];
    if (c < W - 1) rt = frame[k+1];
    return {t, b, l, rt};
  endfunction

  task automatic run_frame(input bit seq_vals, input int gap_pct, input int lim, input bit full);
    int k;
    int budget;
    int exp_c;
    k = 0;
    budget = 0;
    out_cnt = 0;
    ready_low = 0;
    for (int i = 0; i < N; i++) frame[i] = seq_vals ? PW'(i + 1) : PW'($urandom);
    while (((full && out_cnt < N) || (!full && k < lim)) && budget < 400) begin
      @(negedge clk);
      budget++;
      if (o_valid) begin
        if (out_cnt >= N) begin
          check("extra_o_valid", {31'b0, o_valid}, 32'd0);
        end else begin
          exp_c = (out_cnt < N - W) ? acc[out_cnt+W] : acc[N-1] + 1 + (out_cnt - (N - W));
          check("o_data", o_data, model(out_cnt));
          check("o_cycle", cyc, exp_c);
          obs[out_cnt] = o_data;
          out_cnt++;
        end
      end
      if (!i_ready) ready_low++;
      if (k < lim) begin
        i_valid = ($urandom_range(99) >= gap_pct);
        i_pix   = frame[k];
        if (i_valid && i_ready) begin
          acc[k] = cyc + 1;
          k++;
        end
      end else begin
        i_valid = !i_ready;
        i_pix   = PW'($urandom);
      end
    end
    if (full) begin
      check("o_valid_count", out_cnt, N);
      check("flush_ready_low", ready_low, W);
    end else begin
      check("partial_accepted", k, lim);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_o_valid", {31'b0, o_valid}, 32'd0);
      check("idle_i_ready", {31'b0, i_ready}, 32'd1);
    end
  endtask

  task automatic check_known_centres();
`ifdef PIX_WINDOW_REPLICATE_EN
    check("centre_0", obs[0], 32'h01050102);
    check("centre_5", obs[5], 32'h020A0507);
    check("centre_7", obs[7], 32'h040C0708);
    check("centre_11", obs[11], 32'h080C0B0C);
`else
    check("centre_0", obs[0], 32'h00050002);
    check("centre_5", obs[5], 32'h020A0507);
    check("centre_7", obs[7], 32'h040C0700);
    check("centre_11", obs[11], 32'h08000B00);
`endif
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b0;
    i_pix = '0;
    repeat (2) @(negedge clk);
    check("rst_i_ready", {31'b0, i_ready}, 32'd1);
    check("rst_o_valid", {31'b0, o_valid}, 32'd0);
    check("rst_o_data", o_data, 32'd0);
    rst = 1'b1;

    run_frame(1'b1, 0, N, 1'b1);
    check_known_centres();
    idle(3);

    run_frame(1'b1, 40, N, 1'b1);
    check_known_centres();
    idle(2);

    run_frame(1'b1, 30, 7, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_i_ready", {31'b0, i_ready}, 32'd1);
    check("async_rst_o_valid", {31'b0, o_valid}, 32'd0);
    check("async_rst_o_data", o_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_frame(1'b1, 0, N, 1'b1);
    check_known_centres();
    idle(2);

    for (int f = 0; f < 4; f++) begin
      run_frame(1'b0, $urandom_range(60), N, 1'b1);
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
